// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_port_arbiter: round-robin sharing of one cache CPU port between two |
// | requesters, one transaction in flight, with response watchdog.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req_valid,
  input  logic             m0_req_rw,
  input  logic [AW-1:0]    m0_req_addr,
  input  logic [DW-1:0]    m0_req_wdata,
  output logic             m0_req_ready,
  output logic             m0_resp_valid,
  output logic [DW-1:0]    m0_resp_rdata,
  output logic             m0_resp_hit,
  input  logic             m1_req_valid,
  input  logic             m1_req_rw,
  input  logic [AW-1:0]    m1_req_addr,
  input  logic [DW-1:0]    m1_req_wdata,
  output logic             m1_req_ready,
  output logic             m1_resp_valid,
  output logic [DW-1:0]    m1_resp_rdata,
  output logic             m1_resp_hit,
  output logic             c_req_valid,
  output logic             c_req_rw,
  output logic [AW-1:0]    c_req_addr,
  output logic [DW-1:0]    c_req_wdata,
  input  logic             c_resp_valid,
  input  logic [DW-1:0]    c_resp_rdata,
  input  logic             c_hit,
  input  logic             c_ready,
  output logic [CNT_W-1:0] m0_grant_count,
  output logic [CNT_W-1:0] m1_grant_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             c_req_valid_q, c_req_valid_d;
  logic             c_req_rw_q, c_req_rw_d;
  logic [AW-1:0]    c_req_addr_q, c_req_addr_d;
  logic [DW-1:0]    c_req_wdata_q, c_req_wdata_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic          grant;
  logic          accept;
  logic          resp_fire;
  logic          wd_expired;
  logic [DW-1:0] resp_rdata;
  logic          resp_hit;

  always_comb begin
    // A lone requester always wins; contention alternates away from last_grant.
    if (m0_req_valid && m1_req_valid) grant = ~last_grant_q;
    else                              grant = m1_req_valid;
    accept     = (state_q == ST_IDLE) && c_ready && (m0_req_valid || m1_req_valid);
    wd_expired = (state_q == ST_WAIT) && !c_resp_valid && (wd_q == WD_LAST);
    resp_fire  = (state_q == ST_WAIT) && (c_resp_valid || (wd_q == WD_LAST));
    resp_rdata = c_resp_valid ? c_resp_rdata : '0;
    resp_hit   = c_resp_valid & c_hit;
  end

  always_comb begin
    state_d       = state_q;
    c_req_valid_d = c_req_valid_q;
    c_req_rw_d    = c_req_rw_q;
    c_req_addr_d  = c_req_addr_q;
    c_req_wdata_d = c_req_wdata_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    timeout_err_d = timeout_err_q;
    wd_d          = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          c_req_valid_d = 1'b1;
          c_req_rw_d    = grant ? m1_req_rw    : m0_req_rw;
          c_req_addr_d  = grant ? m1_req_addr  : m0_req_addr;
          c_req_wdata_d = grant ? m1_req_wdata : m0_req_wdata;
          owner_d       = grant;
          last_grant_d  = grant;
          if (!grant && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
          if (grant && cnt1_q != CNT_MAX)  cnt1_d = cnt1_q + 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        c_req_valid_d = 1'b0;
        wd_d          = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (resp_fire) state_d = ST_IDLE;
        if (wd_expired) timeout_err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      c_req_valid_q <= 1'b0;
      c_req_rw_q    <= 1'b0;
      c_req_addr_q  <= '0;
      c_req_wdata_q <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      c_req_valid_q <= c_req_valid_d;
      c_req_rw_q    <= c_req_rw_d;
      c_req_addr_q  <= c_req_addr_d;
      c_req_wdata_q <= c_req_wdata_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

  assign m0_req_ready   = accept & ~grant;
  assign m1_req_ready   = accept & grant;
  assign m0_resp_valid  = resp_fire & ~owner_q;
  assign m1_resp_valid  = resp_fire & owner_q;
  assign m0_resp_rdata  = m0_resp_valid ? resp_rdata : '0;
  assign m1_resp_rdata  = m1_resp_valid ? resp_rdata : '0;
  assign m0_resp_hit    = m0_resp_valid & resp_hit;
  assign m1_resp_hit    = m1_resp_valid & resp_hit;
  assign c_req_valid    = c_req_valid_q;
  assign c_req_rw       = c_req_rw_q;
  assign c_req_addr     = c_req_addr_q;
  assign c_req_wdata    = c_req_wdata_q;
  assign m0_grant_count = cnt0_q;
  assign m1_grant_count = cnt1_q;
  assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire
